ppl_pix_wr: RTL and testbench
=============================

# ppl_pix_wr

Pixel write-back stage at the output end of the ray-casting pipeline. It consumes the pipeline's per-pixel result stream (valid, 20-bit pixel address, 13-bit texture address) and issues the texture ROM read. It pairs the returned RGB565 texel with its pixel address, buffers the pair in a small FIFO, and writes it to the framebuffer over a req/ack handshake. It also flags frame completion and counts dropped pixels, because the pipeline has no backpressure input.

## Interface
- H_DISP, 1280, horizontal resolution in pixels
- V_DISP, 720, vertical resolution in pixels; frame size FB_PIXELS = H_DISP*V_DISP
- FIFO_DEPTH, 16, buffer entries; power of two, ≥8
- clk  in  1  pipeline clock; one clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel result valid, single-cycle qualifier
- in_pixel_addr  in  20  linear framebuffer address
- in_texture_addr  in  13  texture ROM address
- tex_addr  out  13  texture ROM read address (registered)
- tex_data  in  16  RGB565 texel; valid exactly 1 cycle after tex_addr is presented
- fb_wr_req  out  1  framebuffer write request
- fb_wr_addr  out  20  write address, stable while fb_wr_req=1
- fb_wr_data  out  16  write data, stable while fb_wr_req=1
- fb_wr_ack  in  1  write accepted; sampled only while fb_wr_req=1
- fifo_afull  out  1  FIFO occupancy ≥ FIFO_DEPTH-4
- frame_done  out  1  one-cycle pulse after the last frame pixel is acked
- ovf_cnt  out  8  saturating count of pixels dropped on FIFO full

## Operation
- Stage 1, on in_valid=1 with in_pixel_addr < FB_PIXELS: register the address and set tex_addr=in_texture_addr. Out-of-range addresses are discarded: stage 1 is not set valid, and ovf_cnt is not incremented.
- Stage 2: tex_data arrives. Push {addr[19:0], texel[15:0]} (36 bits) into the FIFO.
- Push when the FIFO is full and no pop occurs in the same cycle: drop the entry and increment ovf_cnt (saturates at 255). Push and pop in the same cycle while full: both succeed.
- Write FSM, two states:
  - IDLE: fb_wr_req=0. If the FIFO is non-empty, pop into the output registers, set fb_wr_req=1, and go to REQ.
  - REQ: hold req, addr and data until fb_wr_ack=1. On ack with the FIFO non-empty, pop the next entry and stay in REQ (back-to-back, 1 pixel/cycle). On ack with the FIFO empty, drop req and go to IDLE.
- fb_wr_ack while in IDLE is ignored.
- frame_done pulses in the cycle after an ack whose fb_wr_addr == FB_PIXELS-1. Write ordering within the stream is preserved.
- Capacity while ack is stalled is FIFO_DEPTH entries plus 1 in the output register.

## Timing
- Reset values: tex_addr=0, fb_wr_req=0, fb_wr_addr=0, fb_wr_data=0, fifo_afull=0, frame_done=0, ovf_cnt=0. FSM returns to IDLE and the FIFO is emptied.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous). In-flight and buffered pixels are discarded. No stale write occurs after release.
- Latency, with in_valid in cycle N, FSM in IDLE and FIFO empty:
  - tex_addr valid in cycle N+1
  - push at the end of N+2
  - fb_wr_req rises in N+4
- Sustained throughput is 1 pixel/cycle when ack is held high.
- fifo_afull and ovf_cnt are registered and update 1 cycle after the occupancy change or drop.

## Structure
- Shared package ppl_pkg holds:
  - PIX_AW=20, TEX_AW=13, RGB_W=16
  - FB_PIXELS derivation
  - the packed FIFO entry type {addr, rgb}
- One sub-module, ppl_pix_fifo: synchronous FIFO with parameterised depth and width, a registered count, and full/empty/afull outputs. It allows simultaneous push and pop when full.
- The stage registers and the write FSM live in ppl_pix_wr.

## Test plan
- Single pixel: in_valid with addr 0x00005 and tex 0x0123; ROM model returns 0xF800. Required: tex_addr=0x0123 in N+1; fb_wr_req=1 in N+4 with addr 0x00005 and data 0xF800; outputs hold until ack is given 3 cycles later, then req=0.
- Back-to-back: 8 consecutive pixels at addresses 100..107 with ack tied to 1. Required: 8 consecutive write cycles in order 100..107, no gaps, ovf_cnt=0.
- Overflow: ack held 0 while 20 pixels are sent. Required:
  - fifo_afull=1 once 12 entries are queued
  - 17 pixels retained, ovf_cnt=3
  - releasing ack yields exactly 17 writes in order
- Out of range: addr 921600 (=FB_PIXELS). Required: no write, ovf_cnt unchanged, FIFO empty.
- Frame end: pixel 921599 written and acked. Required: frame_done high for exactly 1 cycle, in the cycle after the ack.
- Reset mid-burst: 6 pixels queued, ack=0, then rst=0 for 2 cycles. Required:
  - fb_wr_req=0 and all outputs 0 during reset
  - after release, no write occurs until new input arrives, and ovf_cnt=0

Source files
------------

// File: rtl/ppl_pix_wr_pkg.sv
// Shared widths, frame geometry and the FIFO entry type
// for the pixel write-back stage.
package ppl_pkg;

  localparam int PIX_AW = 20;
  localparam int TEX_AW = 13;
  localparam int RGB_W  = 16;

  function automatic int fb_pixels(input int h, input int v);
    return h * v;
  endfunction

  localparam int FB_PIXELS = fb_pixels(1280, 720);

  typedef struct packed {
    logic [PIX_AW-1:0] addr;
    logic [RGB_W-1:0]  rgb;
  } pix_ent_t;

  localparam int ENT_W = $bits(pix_ent_t);

  typedef enum logic {
    WR_IDLE,
    WR_REQ
  } wr_st_e;

endpackage

// File: rtl/ppl_pix_wr_if.sv
// Pixel stream in, texture ROM port and framebuffer
// write port of the write-back stage.
interface ppl_pix_wr_if;
  import ppl_pkg::*;

  logic              in_valid;
  logic [PIX_AW-1:0] in_pixel_addr;
  logic [TEX_AW-1:0] in_texture_addr;
  logic [TEX_AW-1:0] tex_addr;
  logic [RGB_W-1:0]  tex_data;
  logic              fb_wr_req;
  logic [PIX_AW-1:0] fb_wr_addr;
  logic [RGB_W-1:0]  fb_wr_data;
  logic              fb_wr_ack;
  logic              fifo_afull;
  logic              frame_done;
  logic [7:0]        ovf_cnt;

  modport slave (
    input  in_valid, in_pixel_addr, in_texture_addr,
    input  tex_data, fb_wr_ack,
    output tex_addr, fb_wr_req, fb_wr_addr, fb_wr_data,
    output fifo_afull, frame_done, ovf_cnt
  );

  modport master (
    output in_valid, in_pixel_addr, in_texture_addr,
    output tex_data, fb_wr_ack,
    input  tex_addr, fb_wr_req, fb_wr_addr, fb_wr_data,
    input  fifo_afull, frame_done, ovf_cnt
  );

endinterface

// File: rtl/ppl_pix_wr_fifo.sv
// Synchronous FIFO with registered count; a push into a
// full FIFO succeeds when a pop happens in the same cycle.
module ppl_pix_fifo #(
  parameter int DEPTH  = 16,
  parameter int W      = 36,
  parameter int AF_LVL = DEPTH - 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_afull
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic [AW:0]   w_cnt_nx;
  logic          r_afull;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_afull = r_afull;
  assign o_dout  = r_mem[r_rp];

  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);

  always_comb begin
    w_cnt_nx = r_cnt;
    if (w_wr & ~w_rd)
      w_cnt_nx = r_cnt + (AW+1)'(1);
    else if (~w_wr & w_rd)
      w_cnt_nx = r_cnt - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_afull <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt   <= w_cnt_nx;
      r_afull <= w_cnt_nx >= (AW+1)'(AF_LVL);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_din;
  end

endmodule

// File: rtl/ppl_pix_wr.sv
// Pixel write-back: texture fetch, pixel/texel pairing,
// buffering and framebuffer req/ack writes.
module ppl_pix_wr
  import ppl_pkg::*;
#(
  parameter int H_DISP     = 1280,
  parameter int V_DISP     = 720,
  parameter int FIFO_DEPTH = 16
) (
  input logic          clk,
  input logic          rst,
  ppl_pix_wr_if.slave  bus
);

  localparam int FB_N = fb_pixels(H_DISP, V_DISP);
  localparam logic [PIX_AW-1:0] FB_LIM  = PIX_AW'(FB_N);
  localparam logic [PIX_AW-1:0] FB_LAST = PIX_AW'(FB_N - 1);

  logic              r_s1_v;
  logic [PIX_AW-1:0] r_s1_addr;
  logic [TEX_AW-1:0] r_tex;
  logic              r_s2_v;
  logic [PIX_AW-1:0] r_s2_addr;
  logic              w_in_ok;

  pix_ent_t          w_din;
  pix_ent_t          w_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_afull;
  logic              w_pop;
  logic              w_drop;

  wr_st_e            r_st;
  wr_st_e            w_st_nx;
  logic              r_req;
  logic [PIX_AW-1:0] r_addr;
  logic [RGB_W-1:0]  r_data;
  logic              r_done;
  logic [7:0]        r_ovf;

  assign w_in_ok = bus.in_valid & (bus.in_pixel_addr < FB_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_v    <= 1'b0;
      r_s1_addr <= '0;
      r_tex     <= '0;
      r_s2_v    <= 1'b0;
      r_s2_addr <= '0;
    end else begin
      r_s1_v    <= w_in_ok;
      r_s2_v    <= r_s1_v;
      r_s2_addr <= r_s1_addr;
      if (w_in_ok) begin
        r_s1_addr <= bus.in_pixel_addr;
        r_tex     <= bus.in_texture_addr;
      end
    end
  end

  // texel lands the cycle after r_tex is presented
  assign w_din  = '{addr: r_s2_addr, rgb: bus.tex_data};
  assign w_drop = r_s2_v & w_full & ~w_pop;

  ppl_pix_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .W      (ENT_W),
    .AF_LVL (FIFO_DEPTH - 4)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_s2_v),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_afull (w_afull)
  );

  always_comb begin
    w_st_nx = r_st;
    w_pop   = 1'b0;
    unique case (r_st)
      WR_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_st_nx = WR_REQ;
        end
      end
      WR_REQ: begin
        if (bus.fb_wr_ack) begin
          if (!w_empty) w_pop = 1'b1;
          else w_st_nx = WR_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st   <= WR_IDLE;
      r_req  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_done <= 1'b0;
      r_ovf  <= '0;
    end else begin
      r_st  <= w_st_nx;
      r_req <= w_st_nx == WR_REQ;
      if (w_pop) begin
        r_addr <= w_dout.addr;
        r_data <= w_dout.rgb;
      end
      r_done <= r_req & bus.fb_wr_ack & (r_addr == FB_LAST);
      if (w_drop && r_ovf != 8'hFF)
        r_ovf <= r_ovf + 8'd1;
    end
  end

  assign bus.tex_addr   = r_tex;
  assign bus.fb_wr_req  = r_req;
  assign bus.fb_wr_addr = r_addr;
  assign bus.fb_wr_data = r_data;
  assign bus.fifo_afull = w_afull;
  assign bus.frame_done = r_done;
  assign bus.ovf_cnt    = r_ovf;

endmodule

// File: tb/tb_ppl_pix_wr.sv
// Directed bench for ppl_pix_wr: vector table plus
// hand-written overflow, frame-end and reset sequences.
module tb_ppl_pix_wr;
  import ppl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ppl_pix_wr_if b();

  ppl_pix_wr #(
    .H_DISP     (1280),
    .V_DISP     (720),
    .FIFO_DEPTH (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  typedef struct {
    logic [19:0] a;
    logic [15:0] d;
    int          c;
  } wr_t;

  typedef struct {
    logic [19:0] addr;
    logic [12:0] tex;
    logic [15:0] exp_d;
  } vec_t;

  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  wr_t  wq[$];
  vec_t vt[8];

  function automatic logic [15:0] rom(input logic [12:0] a);
    if (a == 13'h0123) return 16'hF800;
    return {3'b101, a};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    b.tex_data <= rom(b.tex_addr);
    if (rst && b.fb_wr_req && b.fb_wr_ack)
      wq.push_back('{b.fb_wr_addr, b.fb_wr_data, cyc});
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] a, input logic [12:0] t);
    b.in_valid        = 1'b1;
    b.in_pixel_addr   = a;
    b.in_texture_addr = t;
    tick();
    b.in_valid = 1'b0;
  endtask

  task automatic wait_wq(input string nm, input int n, input int lim);
    for (int i = 0; i < lim && wq.size() < n; i++) tick();
    chk(nm, wq.size(), n);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_tex"},  32'(b.tex_addr), 0);
    chk({nm, "_req"},  32'(b.fb_wr_req), 0);
    chk({nm, "_addr"}, 32'(b.fb_wr_addr), 0);
    chk({nm, "_data"}, 32'(b.fb_wr_data), 0);
    chk({nm, "_afl"},  32'(b.fifo_afull), 0);
    chk({nm, "_done"}, 32'(b.frame_done), 0);
    chk({nm, "_ovf"},  32'(b.ovf_cnt), 0);
  endtask

  initial begin
    vt[0] = '{20'd100, 13'h0040, 16'hA040};
    vt[1] = '{20'd101, 13'h0041, 16'hA041};
    vt[2] = '{20'd102, 13'h1FFF, 16'hBFFF};
    vt[3] = '{20'd103, 13'h0000, 16'hA000};
    vt[4] = '{20'd104, 13'h0123, 16'hF800};
    vt[5] = '{20'd105, 13'h0AAA, 16'hAAAA};
    vt[6] = '{20'd106, 13'h1555, 16'hB555};
    vt[7] = '{20'd107, 13'h0007, 16'hA007};

    b.in_valid = 0; b.in_pixel_addr = 0; b.in_texture_addr = 0;
    b.fb_wr_ack = 0;
    repeat (3) tick();
    chk_zero("rst");
    rst = 1'b1;
    tick();

    // single pixel latency and hold
    send(20'h00005, 13'h0123);
    chk("s1_tex", 32'(b.tex_addr), 32'h0123);
    chk("s1_req_n1", 32'(b.fb_wr_req), 0);
    tick(); tick();
    chk("s1_req_n3", 32'(b.fb_wr_req), 0);
    tick();
    chk("s1_req_n4", 32'(b.fb_wr_req), 1);
    chk("s1_addr", 32'(b.fb_wr_addr), 32'h5);
    chk("s1_data", 32'(b.fb_wr_data), 32'hF800);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s1_hold_req", 32'(b.fb_wr_req), 1);
      chk("s1_hold_d", 32'(b.fb_wr_data), 32'hF800);
    end
    b.fb_wr_ack = 1'b1;
    tick();
    b.fb_wr_ack = 1'b0;
    chk("s1_req_off", 32'(b.fb_wr_req), 0);
    chk("s1_nwr", wq.size(), 1);
    wq.delete();

    // back-to-back with ack tied high
    b.fb_wr_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b.in_valid        = 1'b1;
      b.in_pixel_addr   = vt[i].addr;
      b.in_texture_addr = vt[i].tex;
      tick();
    end
    b.in_valid = 1'b0;
    wait_wq("b2b_cnt", 8, 30);
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      chk("b2b_addr", 32'(wq[i].a), 32'(vt[i].addr));
      chk("b2b_data", 32'(wq[i].d), 32'(vt[i].exp_d));
      chk("b2b_gap", wq[i].c - wq[0].c, i);
    end
    chk("b2b_ovf", 32'(b.ovf_cnt), 0);
    tick(); tick();
    b.fb_wr_ack = 1'b0;
    wq.delete();

    // overflow with ack stalled: 1 in output reg + 16 queued
    for (int i = 0; i < 12; i++) send(20'(200 + i), 13'(i));
    repeat (5) tick();
    chk("ovf_afl_11", 32'(b.fifo_afull), 0);
    send(20'd212, 13'd12);
    repeat (5) tick();
    chk("ovf_afl_12", 32'(b.fifo_afull), 1);
    for (int i = 13; i < 20; i++) send(20'(200 + i), 13'(i));
    repeat (5) tick();
    chk("ovf_cnt3", 32'(b.ovf_cnt), 3);
    chk("ovf_afl_full", 32'(b.fifo_afull), 1);
    chk("ovf_nowr", wq.size(), 0);
    b.fb_wr_ack = 1'b1;
    wait_wq("ovf_cnt_wr", 17, 60);
    repeat (5) tick();
    chk("ovf_exact17", wq.size(), 17);
    for (int i = 0; i < 17 && i < wq.size(); i++) begin
      chk("ovf_addr", 32'(wq[i].a), 32'(200 + i));
      chk("ovf_data", 32'(wq[i].d), 32'hA000 + 32'(i));
    end
    b.fb_wr_ack = 1'b0;
    chk("ovf_afl_clr", 32'(b.fifo_afull), 0);
    wq.delete();

    // out-of-range pixel is discarded silently
    send(20'd921600, 13'd1);
    repeat (8) tick();
    chk("oor_nowr", wq.size(), 0);
    chk("oor_req", 32'(b.fb_wr_req), 0);
    chk("oor_ovf", 32'(b.ovf_cnt), 3);

    // last frame pixel
    send(20'd921599, 13'd5);
    for (int i = 0; i < 10 && !b.fb_wr_req; i++) tick();
    chk("fe_req", 32'(b.fb_wr_req), 1);
    chk("fe_addr", 32'(b.fb_wr_addr), 921599);
    tick();
    chk("fe_done_pre", 32'(b.frame_done), 0);
    b.fb_wr_ack = 1'b1;
    tick();
    b.fb_wr_ack = 1'b0;
    chk("fe_done", 32'(b.frame_done), 1);
    tick();
    chk("fe_done_1cyc", 32'(b.frame_done), 0);
    wq.delete();

    // async reset mid-burst
    for (int i = 0; i < 6; i++) send(20'(300 + i), 13'(i));
    repeat (5) tick();
    chk("mr_req_pre", 32'(b.fb_wr_req), 1);
    rst = 1'b0;
    #1;
    chk_zero("mr_async");
    tick(); tick();
    chk_zero("mr_hold");
    rst = 1'b1;
    b.fb_wr_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mr_noreq", 32'(b.fb_wr_req), 0);
    end
    chk("mr_nowr", wq.size(), 0);
    chk("mr_ovf", 32'(b.ovf_cnt), 0);
    send(20'd7, 13'h0123);
    wait_wq("mr_new_cnt", 1, 10);
    if (wq.size() > 0) begin
      chk("mr_new_addr", 32'(wq[0].a), 7);
      chk("mr_new_data", 32'(wq[0].d), 32'hF800);
    end
    b.fb_wr_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule
